// File: rtl/alu_arbiter.sv
// alu_arbiter: one single-cycle ALU shared by N_REQ requesters.
// Round-robin grant, optional short lock for back-to-back sequences, and one
// registered response channel with backpressure.
module alu_arbiter #(
  parameter  int N_REQ    = 2,
  parameter  int MAX_LOCK = 4,
  localparam int ID_W     = (N_REQ > 1) ? $clog2(N_REQ) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_REQ-1:0]    req_valid,
  output logic [N_REQ-1:0]    req_ready,
  input  logic [N_REQ-1:0]    req_lock,
  input  logic [N_REQ*3-1:0]  req_aluop,
  input  logic [N_REQ*32-1:0] req_a,
  input  logic [N_REQ*32-1:0] req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [31:0]         rsp_f
);

  localparam int CNT_W = $clog2(MAX_LOCK);

  typedef enum logic [2:0] {
    OP_ADD, OP_SLL, OP_SRA, OP_SUB, OP_XOR, OP_SRL, OP_OR, OP_AND
  } alu_ops_t;

  typedef enum logic {ST_ARB, ST_LOCKED} state_t;

  state_t          state_q;
  logic [ID_W-1:0] rr_ptr_q;
  logic [ID_W-1:0] owner_q;
  logic [CNT_W-1:0] lock_cnt_q;
  logic            rsp_valid_q;
  logic [ID_W-1:0] rsp_id_q;
  logic [31:0]     rsp_f_q;

  alu_ops_t    op_arr [N_REQ];
  logic [31:0] a_arr  [N_REQ];
  logic [31:0] b_arr  [N_REQ];

  logic            can_accept;
  logic            arb_found;
  logic [ID_W-1:0] arb_idx;
  logic            sel_valid;
  logic [ID_W-1:0] sel_idx;
  logic            fire;
  logic [ID_W-1:0] rr_ptr_d;
  logic [31:0]     alu_f;
  alu_ops_t        alu_op;
  logic [31:0]     alu_a;
  logic [31:0]     alu_b;

  // Unpack the flat per-requester buses into indexable arrays
  genvar gi;
  generate
    for (gi = 0; gi < N_REQ; gi++) begin : g_unpack
      assign op_arr[gi] = alu_ops_t'(req_aluop[gi*3 +: 3]);
      assign a_arr[gi]  = req_a[gi*32 +: 32];
      assign b_arr[gi]  = req_b[gi*32 +: 32];
    end
  endgenerate

  assign can_accept = !rsp_valid_q || rsp_ready;

  // Round-robin search: first valid requester starting at rr_ptr
  always_comb begin
    arb_found = 1'b0;
    arb_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      int pos;
      pos = int'(rr_ptr_q) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      if (!arb_found && req_valid[pos[ID_W-1:0]]) begin
        arb_found = 1'b1;
        arb_idx   = pos[ID_W-1:0];
      end
    end
  end

  // Pick the candidate (owner while locked) and drive a one-hot ready
  always_comb begin
    if (state_q == ST_LOCKED) begin
      sel_idx   = owner_q;
      sel_valid = req_valid[owner_q];
    end else begin
      sel_idx   = arb_idx;
      sel_valid = arb_found;
    end
    fire      = rst && can_accept && sel_valid;
    req_ready = '0;
    if (fire) req_ready[sel_idx] = 1'b1;
    rr_ptr_d  = (sel_idx == ID_W'(N_REQ - 1)) ? '0 : sel_idx + ID_W'(1);
  end

  // Single shared ALU fed by the selected requester's operands
  always_comb begin
    alu_op = op_arr[sel_idx];
    alu_a  = a_arr[sel_idx];
    alu_b  = b_arr[sel_idx];
    case (alu_op)
      OP_ADD:  alu_f = alu_a + alu_b;
      OP_SLL:  alu_f = alu_a << alu_b[4:0];
      OP_SRA:  alu_f = $unsigned($signed(alu_a) >>> alu_b[4:0]);
      OP_SUB:  alu_f = alu_a - alu_b;
      OP_XOR:  alu_f = alu_a ^ alu_b;
      OP_SRL:  alu_f = alu_a >> alu_b[4:0];
      OP_OR:   alu_f = alu_a | alu_b;
      OP_AND:  alu_f = alu_a & alu_b;
      default: alu_f = '0;
    endcase
  end

  // Response register, round-robin pointer and lock FSM
  always_ff @(posedge clk) begin
    if (!rst) begin
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_f_q     <= '0;
      rr_ptr_q    <= '0;
      state_q     <= ST_ARB;
      owner_q     <= '0;
      lock_cnt_q  <= '0;
    end else begin
      if (fire) begin
        rsp_valid_q <= 1'b1;
        rsp_id_q    <= sel_idx;
        rsp_f_q     <= alu_f;
        rr_ptr_q    <= rr_ptr_d;
      end else if (rsp_ready) begin
        rsp_valid_q <= 1'b0;
      end

      case (state_q)
        ST_ARB: begin
          if (fire && req_lock[sel_idx]) begin
            state_q    <= ST_LOCKED;
            owner_q    <= sel_idx;
            lock_cnt_q <= CNT_W'(1);
          end
        end
        ST_LOCKED: begin
          // The lock window runs out whether or not the owner uses it
          if (!req_lock[owner_q] || lock_cnt_q == CNT_W'(MAX_LOCK - 1)) begin
            state_q    <= ST_ARB;
            lock_cnt_q <= '0;
          end else begin
            lock_cnt_q <= lock_cnt_q + CNT_W'(1);
          end
        end
        default: state_q <= ST_ARB;
      endcase
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_f     = rsp_f_q;

  a_ready_onehot: assert property (@(posedge clk) $onehot0(req_ready));
  a_id_range:     assert property (@(posedge clk) disable iff (!rst) int'(rsp_id) < N_REQ);
  a_rsp_hold:     assert property (@(posedge clk) disable iff (!rst)
                    (rsp_valid && !rsp_ready) |=> ($stable(rsp_f) && $stable(rsp_id)));

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed scenarios plus randomized traffic checked
// against a behavioural model of the arbitration and ALU rules.
module tb_alu_arbiter;

  localparam int N  = 2;
  localparam int ML = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [N-1:0]  req_valid = '0;
  logic [N-1:0]  req_ready;
  logic [N-1:0]  req_lock = '0;
  logic [N*3-1:0]  req_aluop = '0;
  logic [N*32-1:0] req_a = '0;
  logic [N*32-1:0] req_b = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [0:0]    rsp_id;
  logic [31:0]   rsp_f;

  int n_checks = 0;
  int n_errors = 0;

  alu_arbiter #(.N_REQ(N), .MAX_LOCK(ML)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_lock  (req_lock),
    .req_aluop (req_aluop),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_f     (rsp_f)
  );

  always #5 clk = ~clk;

  // Reference ALU from the operation definitions (op order: add sll sra sub xor srl or and)
  function automatic logic [31:0] alu_ref(input int op, input logic [31:0] a, input logic [31:0] b);
    int sh;
    sh = int'(b % 32);
    case (op)
      0: return a + b;
      1: return a << sh;
      2: return a[31] ? ~((~a) >> sh) : (a >> sh);
      3: return a - b;
      4: return a ^ b;
      5: return a >> sh;
      6: return a | b;
      default: return a & b;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_req(input int i, input int op, input logic [31:0] a, input logic [31:0] b);
    req_aluop[i*3 +: 3] = 3'(op);
    req_a[i*32 +: 32]   = a;
    req_b[i*32 +: 32]   = b;
  endtask

  task automatic apply_reset();
    rst = 1'b0;
    req_valid = '0;
    req_lock = '0;
    rsp_ready = 1'b1;
    tick();
    tick();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    tick();
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_ready: got %b want 00", req_ready);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_f !== 32'd0 || req_ready !== 2'b00) begin
      n_errors++;
      $display("FAIL reset_state: got valid=%b id=%0d f=%h ready=%b want 0/0/0/00",
               rsp_valid, rsp_id, rsp_f, req_ready);
    end
    $display("test_reset done");
    tick();
  endtask

  // Single add, one-cycle latency
  task automatic test_basic();
    apply_reset();
    drive_req(0, 0, 32'd5, 32'd7);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errors++;
      $display("FAIL basic_ready: got %b want 01", req_ready);
    end
    tick();
    req_valid = 2'b00;
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b0 || rsp_f !== 32'd12) begin
      n_errors++;
      $display("FAIL basic_rsp: got valid=%b id=%0d f=%0d want 1/0/12", rsp_valid, rsp_id, rsp_f);
    end
    $display("test_basic: id=%0d f=%0d", rsp_id, rsp_f);
    tick();
  endtask

  // Two continuous requesters alternate, one response per cycle
  task automatic test_back_to_back();
    int prev;
    apply_reset();
    drive_req(0, 0, 32'd100, 32'd1);
    drive_req(1, 0, 32'd200, 32'd2);
    req_valid = 2'b11;
    rsp_ready = 1'b1;
    prev = -1;
    for (int k = 0; k < 8; k++) begin
      logic [1:0] exp_rdy;
      int g;
      g = k % 2;
      exp_rdy = 2'b01 << g;
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL b2b_grant[%0d]: got %b want %b", k, req_ready, exp_rdy);
      end
      if (prev >= 0) begin
        n_checks++;
        if (rsp_valid !== 1'b1 || int'(rsp_id) != prev || rsp_f !== ((prev == 1) ? 32'd202 : 32'd101)) begin
          n_errors++;
          $display("FAIL b2b_rsp[%0d]: got valid=%b id=%0d f=%0d want id=%0d", k, rsp_valid, rsp_id, rsp_f, prev);
        end
      end
      $display("test_back_to_back: cycle %0d grant=%b", k, req_ready);
      prev = g;
      tick();
    end
    req_valid = 2'b00;
    tick();
  endtask

  // Backpressure stalls acceptance and holds the response; release drains and accepts together
  task automatic test_backpressure();
    apply_reset();
    drive_req(0, 0, 32'd5, 32'd7);
    req_valid = 2'b01;
    rsp_ready = 1'b1;
    tick();
    drive_req(1, 0, 32'd200, 32'd2);
    req_valid = 2'b11;
    rsp_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      n_checks++;
      if (req_ready !== 2'b00 || rsp_valid !== 1'b1 || rsp_f !== 32'd12 || rsp_id !== 1'b0) begin
        n_errors++;
        $display("FAIL bp_hold[%0d]: got ready=%b valid=%b id=%0d f=%0d want 00/1/0/12",
                 k, req_ready, rsp_valid, rsp_id, rsp_f);
      end
      tick();
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_errors++;
      $display("FAIL bp_release_ready: got %b want 10", req_ready);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 1'b1 || rsp_f !== 32'd202 || req_ready !== 2'b01) begin
      n_errors++;
      $display("FAIL bp_drain: got valid=%b id=%0d f=%0d ready=%b want 1/1/202/01",
               rsp_valid, rsp_id, rsp_f, req_ready);
    end
    $display("test_backpressure: drained id=%0d f=%0d", rsp_id, rsp_f);
    req_valid = 2'b00;
    tick();
  endtask

  // Locking requester keeps the grant for exactly MAX_LOCK consecutive cycles
  task automatic test_lock();
    int exp_g[6] = '{0, 0, 0, 0, 1, 0};
    apply_reset();
    drive_req(0, 0, 32'd1, 32'd1);
    drive_req(1, 0, 32'd2, 32'd2);
    req_valid = 2'b11;
    req_lock = 2'b01;
    rsp_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      logic [1:0] exp_rdy;
      exp_rdy = 2'b01 << exp_g[k];
      @(negedge clk);
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL lock_grant[%0d]: got %b want %b", k, req_ready, exp_rdy);
      end
      $display("test_lock: cycle %0d grant=%b", k, req_ready);
      tick();
    end
    req_valid = 2'b00;
    req_lock = 2'b00;
    tick();
  endtask

  // Shift/sub corner values
  task automatic test_alu_corners();
    int          ops[3] = '{2, 3, 1};
    logic [31:0] as[3]  = '{32'h8000_0000, 32'd0, 32'd1};
    logic [31:0] bs[3]  = '{32'h21, 32'd1, 32'd31};
    logic [31:0] fs[3]  = '{32'hC000_0000, 32'hFFFF_FFFF, 32'h8000_0000};
    apply_reset();
    rsp_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_req(0, ops[k], as[k], bs[k]);
      req_valid = 2'b01;
      tick();
      req_valid = 2'b00;
      @(negedge clk);
      n_checks++;
      if (rsp_valid !== 1'b1 || rsp_f !== fs[k]) begin
        n_errors++;
        $display("FAIL alu_corner[%0d]: got valid=%b f=%h want 1/%h", k, rsp_valid, rsp_f, fs[k]);
      end
      $display("test_alu_corners: op=%0d f=%h", ops[k], rsp_f);
      tick();
    end
  endtask

  // Reset while locked with a held response clears everything
  task automatic test_reset_locked();
    apply_reset();
    drive_req(0, 0, 32'd3, 32'd4);
    drive_req(1, 0, 32'd9, 32'd9);
    req_valid = 2'b01;
    req_lock = 2'b01;
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b00 || rsp_valid !== 1'b1) begin
      n_errors++;
      $display("FAIL rstlock_pre: got ready=%b valid=%b want 00/1", req_ready, rsp_valid);
    end
    tick();
    @(negedge clk);
    n_checks++;
    if (rsp_valid !== 1'b0 || rsp_id !== 1'b0 || rsp_f !== 32'd0) begin
      n_errors++;
      $display("FAIL rstlock_rsp: got valid=%b id=%0d f=%h want 0/0/0", rsp_valid, rsp_id, rsp_f);
    end
    tick();
    rst = 1'b1;
    req_lock = 2'b00;
    rsp_ready = 1'b1;
    req_valid = 2'b11;
    @(negedge clk);
    n_checks++;
    if (req_ready !== 2'b01) begin
      n_errors++;
      $display("FAIL rstlock_rrptr: got %b want 01", req_ready);
    end
    req_valid = 2'b10;
    #1;
    n_checks++;
    if (req_ready !== 2'b10) begin
      n_errors++;
      $display("FAIL rstlock_arb: got %b want 10", req_ready);
    end
    $display("test_reset_locked done");
    tick();
    req_valid = 2'b00;
    tick();
  endtask

  // Random traffic against a behavioural model of the arbitration rules
  task automatic test_random();
    int m_rr, m_owner, m_cnt, m_id;
    bit m_locked, m_rv;
    logic [31:0] m_f;
    bit pend[N];
    int pop[N];
    logic [31:0] pa[N];
    logic [31:0] pb[N];
    int n_fire;
    apply_reset();
    m_rr = 0; m_owner = 0; m_cnt = 0; m_id = 0;
    m_locked = 0; m_rv = 0; m_f = '0; n_fire = 0;
    for (int i = 0; i < N; i++) begin
      pend[i] = 0; pop[i] = 0; pa[i] = '0; pb[i] = '0;
    end
    for (int cyc = 0; cyc < 800; cyc++) begin
      bit can;
      int g;
      logic [1:0] exp_rdy;
      for (int i = 0; i < N; i++) begin
        if (!pend[i] && $urandom_range(0, 3) != 0) begin
          pend[i] = 1;
          pop[i]  = int'($urandom_range(0, 7));
          pa[i]   = $urandom;
          pb[i]   = ($urandom_range(0, 1) != 0) ? $urandom : 32'($urandom_range(0, 40));
        end
        req_valid[i] = pend[i];
        drive_req(i, pop[i], pa[i], pb[i]);
        req_lock[i] = ($urandom_range(0, 2) != 0);
      end
      rsp_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      can = !m_rv || rsp_ready;
      g = -1;
      if (can) begin
        if (m_locked) begin
          if (pend[m_owner]) g = m_owner;
        end else begin
          for (int k = 0; k < N; k++) begin
            int c;
            c = (m_rr + k) % N;
            if (g < 0 && pend[c]) g = c;
          end
        end
      end
      exp_rdy = (g >= 0) ? (2'b01 << g) : 2'b00;
      n_checks++;
      if (req_ready !== exp_rdy) begin
        n_errors++;
        $display("FAIL rnd_ready[%0d]: got %b want %b", cyc, req_ready, exp_rdy);
      end
      n_checks++;
      if (rsp_valid !== m_rv) begin
        n_errors++;
        $display("FAIL rnd_valid[%0d]: got %b want %b", cyc, rsp_valid, m_rv);
      end
      if (m_rv) begin
        n_checks++;
        if (int'(rsp_id) != m_id || rsp_f !== m_f) begin
          n_errors++;
          $display("FAIL rnd_rsp[%0d]: got id=%0d f=%h want id=%0d f=%h", cyc, rsp_id, rsp_f, m_id, m_f);
        end
      end
      @(posedge clk);
      if (g >= 0) begin
        m_rv = 1;
        m_id = g;
        m_f  = alu_ref(pop[g], pa[g], pb[g]);
        m_rr = (g + 1) % N;
        pend[g] = 0;
        n_fire++;
      end else if (rsp_ready) begin
        m_rv = 0;
      end
      if (m_locked) begin
        if (!req_lock[m_owner] || m_cnt == ML - 1) begin
          m_locked = 0;
          m_cnt = 0;
        end else begin
          m_cnt++;
        end
      end else if (g >= 0 && req_lock[g]) begin
        m_locked = 1;
        m_owner = g;
        m_cnt = 1;
      end
      #1;
    end
    $display("test_random: %0d requests accepted", n_fire);
    req_valid = '0;
    req_lock = '0;
    tick();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_back_to_back();
    test_backpressure();
    test_lock();
    test_alu_corners();
    test_reset_locked();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
